// File: rtl/przerwania_ctrl.sv
// -----------------------------------------------------------------------------
// przerwania_ctrl -- fixed-priority interrupt controller
//
// Collects single-cycle interrupt pulses from N_SRC peripherals into pending
// bits, picks the lowest-numbered pending and enabled source, and presents one
// request plus a vector address to the CPU. After the CPU acknowledges, it
// pulses flaga_clear back to the serviced peripheral. It then waits in SERVICE
// until the CPU returns from the handler. Handlers do not nest.
// Source 0 (the timer, licznik_int) has the highest priority.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous reset, active low
//   irq_in       single-cycle interrupt pulses, one bit per source
//   wartosc      8-bit bus write data
//   zapisz_mask  write mask register from wartosc[N_SRC-1:0] (1 = enabled)
//   zapisz_clr   write-1-to-clear pending bits from wartosc[N_SRC-1:0]
//   zapisz_ctr   write control register, wartosc[7] = global enable (gie)
//   cpu_ack      CPU takes the presented vector
//   cpu_reti     CPU returns from the handler
//   cpu_irq      interrupt request to the CPU
//   cpu_vec      vector address, valid while cpu_irq is high
//   flaga_clear  one-cycle pulse clearing the serviced peripheral's flag
//   pending      pending bits (status)
//   aktywne      a handler is in service
// -----------------------------------------------------------------------------
module przerwania_ctrl #(
    parameter int          N_SRC      = 4,
    parameter int          ADDR_W     = 8,
    parameter int unsigned VEC_BASE   = 32'h08,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic [7:0]        wartosc,
    input  logic              zapisz_mask,
    input  logic              zapisz_clr,
    input  logic              zapisz_ctr,
    input  logic              cpu_ack,
    input  logic              cpu_reti,
    output logic              cpu_irq,
    output logic [ADDR_W-1:0] cpu_vec,
    output logic [N_SRC-1:0]  flaga_clear,
    output logic [N_SRC-1:0]  pending,
    output logic              aktywne
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [N_SRC-1:0]  mask;
    logic              gie;
    logic [IDX_W-1:0]  idx;

    // ------------------------------------------------------------------
    // Bus write decode: only one register is written per cycle, and
    // ctrl beats mask beats clr.
    // ------------------------------------------------------------------
    logic wr_ctr;
    logic wr_mask;
    logic wr_clr;

    assign wr_ctr  = zapisz_ctr;
    assign wr_mask = zapisz_mask & ~zapisz_ctr;
    assign wr_clr  = zapisz_clr  & ~zapisz_ctr & ~zapisz_mask;

    // Bits of wartosc that no register uses with this N_SRC.
    logic unused_wartosc;
    assign unused_wartosc = ^wartosc;

    // ------------------------------------------------------------------
    // Arbitration: lowest pending and enabled index wins.
    // ------------------------------------------------------------------
    logic [N_SRC-1:0]  req_vec;
    logic              req_any;
    logic [IDX_W-1:0]  winner;
    logic [ADDR_W-1:0] winner_vec;

    assign req_vec = pending & mask;
    assign req_any = gie & (|req_vec);

    // NOTE: every signal driven from always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        winner = '0;
        // Walk from the highest index down so the lowest set bit is written last.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    assign winner_vec = ADDR_W'(VEC_BASE + VEC_STRIDE * 32'(winner));

    // One-hot of the latched source, used for the ack clear, the
    // flag-clear pulse and the withdraw checks.
    logic [N_SRC-1:0] idx_oh;
    assign idx_oh = N_SRC'(1) << idx;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic ack_take;
    logic withdraw;

    assign ack_take = (state == ST_REQ) & cpu_ack;
    assign withdraw = ~gie | ~(|(idx_oh & mask)) | ~(|(idx_oh & pending));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_any) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack in the same cycle as a withdraw condition still wins:
                // the CPU has already committed to the vector.
                if (cpu_ack) begin
                    state_nxt = ST_SERVICE;
                end else if (withdraw) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (cpu_reti) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pending bits: clears first, then new pulses, so an irq arriving in
    // the same cycle as its own clear or ack is never lost.
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] pending_nxt;

    always_comb begin
        pending_nxt = pending;
        if (wr_clr) begin
            pending_nxt = pending_nxt & ~wartosc[N_SRC-1:0];
        end
        if (ack_take) begin
            pending_nxt = pending_nxt & ~idx_oh;
        end
        pending_nxt = pending_nxt | irq_in;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and evaluation order inside the block is irrelevant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            cpu_vec     <= '0;
            flaga_clear <= '0;
            pending     <= '0;
            mask        <= '0;
            gie         <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            flaga_clear <= ack_take ? idx_oh : '0;

            // Source and vector are frozen for the whole REQ phase.
            if ((state == ST_IDLE) && req_any) begin
                idx     <= winner;
                cpu_vec <= winner_vec;
            end

            if (wr_ctr) begin
                gie <= wartosc[7];
            end
            if (wr_mask) begin
                mask <= wartosc[N_SRC-1:0];
            end
        end
    end

    // Request and in-service flags decode the state register directly, so no
    // input reaches them combinationally.
    assign cpu_irq = (state == ST_REQ);
    assign aktywne = (state == ST_SERVICE);

endmodule

// File: tb/tb_przerwania_ctrl.sv
module tb_przerwania_ctrl;

    localparam int N_SRC = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       irq_in;
    logic [7:0]       wartosc;
    logic             zapisz_mask;
    logic             zapisz_clr;
    logic             zapisz_ctr;
    logic             cpu_ack;
    logic             cpu_reti;
    logic             cpu_irq;
    logic [7:0]       cpu_vec;
    logic [3:0]       flaga_clear;
    logic [3:0]       pending;
    logic             aktywne;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    przerwania_ctrl #(
        .N_SRC     (N_SRC),
        .ADDR_W    (8),
        .VEC_BASE  (32'h08),
        .VEC_STRIDE(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .wartosc    (wartosc),
        .zapisz_mask(zapisz_mask),
        .zapisz_clr (zapisz_clr),
        .zapisz_ctr (zapisz_ctr),
        .cpu_ack    (cpu_ack),
        .cpu_reti   (cpu_reti),
        .cpu_irq    (cpu_irq),
        .cpu_vec    (cpu_vec),
        .flaga_clear(flaga_clear),
        .pending    (pending),
        .aktywne    (aktywne)
    );

    typedef struct {
        logic [3:0] irq;
        logic [7:0] wd;
        logic       m;
        logic       c;
        logic       t;
        logic       ack;
        logic       reti;
        logic       e_irq;
        logic [7:0] e_vec;
        logic [3:0] e_fc;
        logic [3:0] e_pend;
        logic       e_akt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] irq, input logic [7:0] wd,
                       input logic m, input logic c, input logic t,
                       input logic ack, input logic reti,
                       input logic e_irq, input logic [7:0] e_vec,
                       input logic [3:0] e_fc, input logic [3:0] e_pend,
                       input logic e_akt);
        vec_t v;
        v.irq = irq; v.wd = wd; v.m = m; v.c = c; v.t = t;
        v.ack = ack; v.reti = reti;
        v.e_irq = e_irq; v.e_vec = e_vec; v.e_fc = e_fc;
        v.e_pend = e_pend; v.e_akt = e_akt;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_irq,
                             input logic [7:0] e_vec, input logic [3:0] e_fc,
                             input logic [3:0] e_pend, input logic e_akt);
        check({tag, " cpu_irq"},     32'(cpu_irq),     32'(e_irq));
        check({tag, " cpu_vec"},     32'(cpu_vec),     32'(e_vec));
        check({tag, " flaga_clear"}, 32'(flaga_clear), 32'(e_fc));
        check({tag, " pending"},     32'(pending),     32'(e_pend));
        check({tag, " aktywne"},     32'(aktywne),     32'(e_akt));
    endtask

    // Drive one cycle of inputs at the falling edge, then return 1 time unit
    // after the following rising edge so outputs can be sampled.
    task automatic step(input logic [3:0] irq, input logic [7:0] wd,
                        input logic m, input logic c, input logic t,
                        input logic ack, input logic reti);
        @(negedge clk);
        irq_in = irq; wartosc = wd; zapisz_mask = m; zapisz_clr = c;
        zapisz_ctr = t; cpu_ack = ack; cpu_reti = reti;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        irq_in = '0; wartosc = '0; zapisz_mask = 1'b0; zapisz_clr = 1'b0;
        zapisz_ctr = 1'b0; cpu_ack = 1'b0; cpu_reti = 1'b0;
        #2;
        check_all("reset", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        //   irq  wd     m  c  t  ak rt   irq vec    fc    pend  akt
        // basic service of source 0
        add(4'h0, 8'h80, 0, 0, 1, 0, 0,   0, 8'h00, 4'h0, 4'h0, 0);
        add(4'h0, 8'h01, 1, 0, 0, 0, 0,   0, 8'h00, 4'h0, 4'h0, 0);
        add(4'h1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h00, 4'h0, 4'h1, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h08, 4'h0, 4'h1, 0);
        add(4'h0, 8'h00, 0, 0, 0, 1, 0,   0, 8'h08, 4'h1, 4'h0, 1);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h0, 1);
        add(4'h0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h08, 4'h0, 4'h0, 0);
        // priority: src1 and src3 together
        add(4'h0, 8'h0F, 1, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h0, 0);
        add(4'hA, 8'h00, 0, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'hA, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h0C, 4'h0, 4'hA, 0);
        add(4'h0, 8'h00, 0, 0, 0, 1, 0,   0, 8'h0C, 4'h2, 4'h8, 1);
        add(4'h0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h0C, 4'h0, 4'h8, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h14, 4'h0, 4'h8, 0);
        add(4'h0, 8'h00, 0, 0, 0, 1, 0,   0, 8'h14, 4'h8, 4'h0, 1);
        add(4'h0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h14, 4'h0, 4'h0, 0);
        // masking: src2 waits until unmasked
        add(4'h0, 8'h00, 1, 0, 0, 0, 0,   0, 8'h14, 4'h0, 4'h0, 0);
        add(4'h4, 8'h00, 0, 0, 0, 0, 0,   0, 8'h14, 4'h0, 4'h4, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h14, 4'h0, 4'h4, 0);
        add(4'h0, 8'h04, 1, 0, 0, 0, 0,   0, 8'h14, 4'h0, 4'h4, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h10, 4'h0, 4'h4, 0);
        add(4'h0, 8'h00, 0, 0, 0, 1, 0,   0, 8'h10, 4'h4, 4'h0, 1);
        add(4'h0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h10, 4'h0, 4'h0, 0);
        // race: irq of src0 with its own ack, then clr withdraw
        add(4'h0, 8'h01, 1, 0, 0, 0, 0,   0, 8'h10, 4'h0, 4'h0, 0);
        add(4'h1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h10, 4'h0, 4'h1, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h08, 4'h0, 4'h1, 0);
        add(4'h1, 8'h00, 0, 0, 0, 1, 0,   0, 8'h08, 4'h1, 4'h1, 1);
        add(4'h0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h08, 4'h0, 4'h1, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h08, 4'h0, 4'h1, 0);
        add(4'h0, 8'h01, 0, 1, 0, 0, 0,   1, 8'h08, 4'h0, 4'h0, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h0, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h0, 0);
        // no nesting: src0 arrives while src0 handler runs
        add(4'h1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h1, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h08, 4'h0, 4'h1, 0);
        add(4'h0, 8'h00, 0, 0, 0, 1, 0,   0, 8'h08, 4'h1, 4'h0, 1);
        add(4'h1, 8'h00, 0, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h1, 1);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h1, 1);
        add(4'h0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h08, 4'h0, 4'h1, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h08, 4'h0, 4'h1, 0);
        add(4'h0, 8'h00, 0, 0, 0, 1, 0,   0, 8'h08, 4'h1, 4'h0, 1);
        add(4'h0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h08, 4'h0, 4'h0, 0);
        // upper wartosc bits ignored, write priority, gie withdraw
        add(4'h2, 8'hF0, 1, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h2, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h2, 0);
        add(4'h0, 8'h02, 1, 0, 1, 0, 0,   0, 8'h08, 4'h0, 4'h2, 0);
        add(4'h0, 8'h02, 1, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h2, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h08, 4'h0, 4'h2, 0);
        add(4'h0, 8'h80, 0, 0, 1, 0, 0,   0, 8'h08, 4'h0, 4'h2, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   1, 8'h0C, 4'h0, 4'h2, 0);
        add(4'h0, 8'h00, 0, 0, 1, 0, 0,   1, 8'h0C, 4'h0, 4'h2, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 0,   0, 8'h0C, 4'h0, 4'h2, 0);
        add(4'h0, 8'h00, 0, 0, 0, 1, 0,   0, 8'h0C, 4'h0, 4'h2, 0);
        add(4'h0, 8'h02, 1, 1, 0, 0, 0,   0, 8'h0C, 4'h0, 4'h2, 0);
        add(4'h0, 8'hF2, 0, 1, 0, 0, 0,   0, 8'h0C, 4'h0, 4'h0, 0);
        add(4'h0, 8'h00, 0, 0, 0, 0, 1,   0, 8'h0C, 4'h0, 4'h0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].irq, tbl[i].wd, tbl[i].m, tbl[i].c, tbl[i].t,
                 tbl[i].ack, tbl[i].reti);
            check_all($sformatf("vec%0d", i), tbl[i].e_irq, tbl[i].e_vec,
                      tbl[i].e_fc, tbl[i].e_pend, tbl[i].e_akt);
        end

        // Asynchronous reset in the middle of a request.
        step(4'h0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'h0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'h1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre-reset cpu_irq", 32'(cpu_irq), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all("async reset", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        // gie and mask must have been cleared too: a new pulse only pends.
        step(4'h1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("post-reset", 1'b0, 8'h00, 4'h0, 4'h1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
